// File: rtl/multiplicador_4bits_pkg.sv
// Shared constants for the 4-bit shift-add multiplier: FSM encodings and step count.
package multiplicador_4bits_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] CALC = 2'b01;
  localparam logic [1:0] FIM  = 2'b10;

  localparam int N_PASSOS = 4;

  // Counter value on the final shift-add step.
  localparam logic [1:0] ULTIMO_PASSO = 2'(N_PASSOS - 1);

endpackage

// File: rtl/multiplicador_4bits_somador.sv
// Combinational 4-bit unsigned adder with carry-out (somador4Bits).
module somador4Bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/multiplicador_4bits.sv
// Sequential 4x4 unsigned shift-add multiplier: one add/shift step per clock, 4 steps per product.
module multiplicador_4bits
  import multiplicador_4bits_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P,
  output logic       BUSY,
  output logic       DONE
);

  logic [1:0] state_q, state_d;
  logic [3:0] m_q, m_d;
  logic [3:0] q_q, q_d;
  logic [3:0] acc_q, acc_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] p_q, p_d;

  logic [3:0] soma;
  logic       carry;
  logic [7:0] deslocado;

  somador4Bits u_somador (
    .a    (acc_q),
    .b    (m_q),
    .s    (soma),
    .cout (carry)
  );

  // Carry-out lands in ACC[3] after the shift, so no product bit is ever lost.
  always_comb begin
    if (q_q[0]) begin
      deslocado = {carry, soma, q_q[3:1]};
    end else begin
      deslocado = {1'b0, acc_q, q_q[3:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          m_d     = A;
          q_d     = B;
          acc_d   = 4'd0;
          cnt_d   = 2'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        {acc_d, q_d} = deslocado;
        cnt_d        = cnt_q + 2'd1;
        if (cnt_q == ULTIMO_PASSO) begin
          p_d     = deslocado;
          state_d = FIM;
        end
      end
      FIM: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      m_q     <= 4'd0;
      q_q     <= 4'd0;
      acc_q   <= 4'd0;
      cnt_q   <= 2'd0;
      p_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  // Status flags decode the state register directly, so reset clears them at once.
  assign P    = p_q;
  assign BUSY = (state_q == CALC);
  assign DONE = (state_q == FIM);

endmodule

// File: tb/tb_multiplicador_4bits.sv
// Directed-vector bench for multiplicador_4bits: table of products plus reset, back-to-back and START-noise sequences.
module tb_multiplicador_4bits;

  logic       CLK;
  logic       RST_N;
  logic       START;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] P;
  logic       BUSY;
  logic       DONE;

  int n_vec;
  int n_fail;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p_exp;
    bit         disturb;
  } vec_t;

  vec_t tabela[6];

  multiplicador_4bits dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .A     (A),
    .B     (B),
    .P     (P),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One operation: accept at t0, scramble A/B afterwards, watch 8 cycles.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] p_exp,
                       input bit disturb, input bit verbose);
    int         busy_n;
    int         done_n;
    int         done_at;
    logic [7:0] p_at;
    @(negedge CLK);
    A     = a;
    B     = b;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    A     = ~a;
    B     = ~b;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    p_at    = 8'hxx;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (BUSY === 1'b1) busy_n++;
      if (DONE === 1'b1) begin
        done_n++;
        done_at = i;
        p_at    = P;
      end
      if (disturb && i < 3) begin
        START = (i % 2 == 0);
        A     = 4'(i + 9);
        B     = 4'(15 - i);
      end else begin
        START = 1'b0;
      end
    end
    chk("busy_cycles", busy_n, 4);
    chk("done_pulses", done_n, 1);
    chk("done_latency", done_at, 4);
    chk("product", {24'd0, p_at}, {24'd0, p_exp});
    if (verbose)
      $display("op A=%0d B=%0d disturb=%0d -> P=%0d (exp %0d) busy=%0d done=%0d",
               a, b, disturb, p_at, p_exp, busy_n, done_n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_done;
    int second_done;
    int done_n;

    n_vec  = 0;
    n_fail = 0;
    tabela[0] = '{4'd3,  4'd5,  8'h0F, 1'b0};
    tabela[1] = '{4'd15, 4'd15, 8'hE1, 1'b0};
    tabela[2] = '{4'd7,  4'd0,  8'h00, 1'b0};
    tabela[3] = '{4'd6,  4'd7,  8'h2A, 1'b1};
    tabela[4] = '{4'd0,  4'd9,  8'h00, 1'b0};
    tabela[5] = '{4'd13, 4'd11, 8'h8F, 1'b1};

    START = 1'b0;
    A     = 4'd0;
    B     = 4'd0;
    RST_N = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    chk("reset_P", {24'd0, P}, 32'd0);
    chk("reset_BUSY", {31'd0, BUSY}, 32'd0);
    chk("reset_DONE", {31'd0, DONE}, 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    for (int k = 0; k < 6; k++)
      do_op(tabela[k].a, tabela[k].b, tabela[k].p_exp, tabela[k].disturb, 1'b1);

    // Back-to-back with START held: second start must follow 6 cycles after the first.
    @(negedge CLK);
    A = 4'd2;
    B = 4'd3;
    START = 1'b1;
    @(posedge CLK);
    first_done  = -1;
    second_done = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin
        if (first_done < 0) begin
          first_done = i;
          chk("b2b_first_P", {24'd0, P}, 32'd6);
          A = 4'd9;
          B = 4'd9;
        end else if (second_done < 0) begin
          second_done = i;
          chk("b2b_second_P", {24'd0, P}, 32'd81);
          START = 1'b0;
        end
      end
    end
    chk("b2b_first_latency", first_done, 4);
    chk("b2b_period", second_done - first_done, 6);
    $display("b2b A=2,B=3 then A=9,B=9 -> done at cycles %0d and %0d", first_done, second_done);
    repeat (4) @(negedge CLK);

    // Reset asserted in the third CALC cycle, between clock edges.
    @(negedge CLK);
    A     = 4'd15;
    B     = 4'd15;
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("abort_P", {24'd0, P}, 32'd0);
    chk("abort_BUSY", {31'd0, BUSY}, 32'd0);
    chk("abort_DONE", {31'd0, DONE}, 32'd0);
    @(negedge CLK);
    RST_N  = 1'b1;
    done_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) done_n++;
    end
    chk("abort_no_done", done_n, 0);
    chk("abort_P_held", {24'd0, P}, 32'd0);
    $display("reset mid-CALC -> P=%0d, done pulses after abort=%0d", P, done_n);
    do_op(4'd4, 4'd4, 8'd16, 1'b0, 1'b1);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        do_op(4'(a), 4'(b), 8'(a * b), 1'b0, 1'b0);
    $display("sweep 16x16 operand pairs complete");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
